// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux_pkg
// Brief    : Shared select-width, input-count and latency constants for the
//            registered 8:1 multiplexer family.
// Revision : 1.0
// ============================================================================
package mux_pkg;

  localparam int SEL_W       = 3;
  localparam int NUM_IN      = 8;
  localparam int MAX_LATENCY = 4;

  typedef logic [SEL_W-1:0] sel_t;

  localparam sel_t SEL_IN0 = 3'd0;
  localparam sel_t SEL_IN1 = 3'd1;
  localparam sel_t SEL_IN2 = 3'd2;
  localparam sel_t SEL_IN3 = 3'd3;
  localparam sel_t SEL_IN4 = 3'd4;
  localparam sel_t SEL_IN5 = 3'd5;
  localparam sel_t SEL_IN6 = 3'd6;
  localparam sel_t SEL_IN7 = 3'd7;

endpackage
`default_nettype wire

// File: rtl/mux8_1bit_sync_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage
// Brief    : W-bit register with synchronous active-high clear.
// Revision : 1.0
// ============================================================================
module pipe_stage #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] data_d;
  logic [W-1:0] data_q;

  always_comb begin
    data_d = d;
    if (rst) begin
      data_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign q = data_q;

endmodule
`default_nettype wire

// File: rtl/mux8_1bit_sync.sv
`default_nettype none
// ============================================================================
// Module   : mux8_1bit_sync
// Brief    : Registered 8:1 multiplexer with LATENCY stages of {data, valid}.
//            Define MUX8_1BIT_COMB_OUT_EN to add the unregistered out_comb port.
// Revision : 1.0
// ============================================================================
module mux8_1bit_sync
  import mux_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_0,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic [WIDTH-1:0] in_3,
  input  logic [WIDTH-1:0] in_4,
  input  logic [WIDTH-1:0] in_5,
  input  logic [WIDTH-1:0] in_6,
  input  logic [WIDTH-1:0] in_7,
  input  logic [2:0]       sel,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
`ifdef MUX8_1BIT_COMB_OUT_EN
  ,
  output logic [WIDTH-1:0] out_comb
`endif
);

  logic [WIDTH-1:0] sel_data;
  logic [WIDTH:0]   stage [0:LATENCY];

  // Every code is decoded, so only the addressed input can reach sel_data.
  always_comb begin
    sel_data = '0;
    case (sel)
      SEL_IN0: sel_data = in_0;
      SEL_IN1: sel_data = in_1;
      SEL_IN2: sel_data = in_2;
      SEL_IN3: sel_data = in_3;
      SEL_IN4: sel_data = in_4;
      SEL_IN5: sel_data = in_5;
      SEL_IN6: sel_data = in_6;
      SEL_IN7: sel_data = in_7;
    endcase
  end

  assign stage[0] = {sel_data, in_valid};

  for (genvar k = 1; k <= LATENCY; k++) begin : g_stage
    pipe_stage #(
      .W (WIDTH + 1)
    ) u_stage (
      .clk (clk),
      .rst (rst),
      .d   (stage[k-1]),
      .q   (stage[k])
    );
  end

  assign out       = stage[LATENCY][WIDTH:1];
  assign out_valid = stage[LATENCY][0];

`ifdef MUX8_1BIT_COMB_OUT_EN
  assign out_comb = sel_data;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux8_1bit_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux8_1bit_sync
// Brief    : Scoreboard bench for mux8_1bit_sync with WIDTH=1, LATENCY=3.
// Revision : 1.0
// ============================================================================
module tb_mux8_1bit_sync;

  localparam int WIDTH   = 1;
  localparam int LATENCY = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ins;
  logic [2:0] sel;
  logic       in_valid;
  logic       out;
  logic       out_valid;
`ifdef MUX8_1BIT_COMB_OUT_EN
  logic       out_comb;
`endif

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Each entry is the {out_valid, out} pair expected after one clock edge.
  logic [1:0] exp_q [$];

  always #5 clk = ~clk;

  mux8_1bit_sync #(
    .WIDTH   (WIDTH),
    .LATENCY (LATENCY)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_0      (ins[0]),
    .in_1      (ins[1]),
    .in_2      (ins[2]),
    .in_3      (ins[3]),
    .in_4      (ins[4]),
    .in_5      (ins[5]),
    .in_6      (ins[6]),
    .in_7      (ins[7]),
    .sel       (sel),
    .in_valid  (in_valid),
    .out       (out),
    .out_valid (out_valid)
`ifdef MUX8_1BIT_COMB_OUT_EN
    ,
    .out_comb  (out_comb)
`endif
  );

  typedef struct {
    logic [7:0] ins;
    logic [2:0] sel;
    logic       vld;
    logic       exp;
  } vec_t;

  // Bit N of ins drives in_N; exp is the hand-derived value of in_sel.
  vec_t vecs [12] = '{
    '{8'hA6, 3'd3, 1'b1, 1'b0},
    '{8'hA6, 3'd2, 1'b1, 1'b1},
    '{8'hA6, 3'd7, 1'b1, 1'b1},
    '{8'hA6, 3'd0, 1'b1, 1'b0},
    '{8'hA6, 3'd5, 1'b1, 1'b1},
    '{8'h5A, 3'd0, 1'b1, 1'b0},
    '{8'h5A, 3'd1, 1'b1, 1'b1},
    '{8'h5A, 3'd6, 1'b0, 1'b1},
    '{8'hF0, 3'd4, 1'b1, 1'b1},
    '{8'hF0, 3'd3, 1'b1, 1'b0},
    '{8'h81, 3'd7, 1'b1, 1'b1},
    '{8'h81, 3'd6, 1'b1, 1'b0}
  };

  task automatic apply(input logic [7:0] i_ins, input logic [2:0] i_sel,
                       input logic i_vld, input logic i_rst, input logic i_exp);
    ins      = i_ins;
    sel      = i_sel;
    in_valid = i_vld;
    rst      = i_rst;
`ifdef MUX8_1BIT_COMB_OUT_EN
    #1;
    chk_cnt++;
    if (out_comb === i_exp) pass_cnt++;
    else $display("FAIL out_comb: got %b expected %b (sel=%0d)", out_comb, i_exp, i_sel);
`endif
    @(posedge clk);
    if (i_rst) begin
      exp_q.delete();
      for (int i = 0; i < LATENCY; i++) exp_q.push_back(2'b00);
    end else begin
      exp_q.push_back({i_vld, i_exp});
    end
    #1;
  endtask

  // Monitor: one expected entry retires per clock edge once the queue is primed.
  initial begin
    logic [1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk_cnt++;
        if ({out_valid, out} === e) pass_cnt++;
        else $display("FAIL out/out_valid: got valid=%b out=%b expected valid=%b out=%b",
                      out_valid, out, e[1], e[0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ins      = '0;
    sel      = '0;
    in_valid = 1'b0;
    rst      = 1'b1;

    apply(8'h00, 3'd0, 1'b0, 1'b1, 1'b0);
    apply(8'h00, 3'd0, 1'b0, 1'b1, 1'b0);

    // One-hot then inverted one-hot for every select code.
    for (int s = 0; s < 8; s++) begin
      logic [7:0] oh;
      oh = 8'h01 << s;
      apply(oh, 3'(s), 1'b1, 1'b0, 1'b1);
      apply(~oh, 3'(s), 1'b1, 1'b0, 1'b0);
    end

    foreach (vecs[i]) apply(vecs[i].ins, vecs[i].sel, vecs[i].vld, 1'b0, vecs[i].exp);

    // Unselected inputs at X must not reach out.
    apply(8'bxxxx_1xxx, 3'd3, 1'b1, 1'b0, 1'b1);
    apply(8'bxxxx_xxx0, 3'd0, 1'b1, 1'b0, 1'b0);

    // in_valid toggling with in_5 held high.
    apply(8'h20, 3'd5, 1'b1, 1'b0, 1'b1);
    apply(8'h20, 3'd5, 1'b0, 1'b0, 1'b1);
    apply(8'h20, 3'd5, 1'b1, 1'b0, 1'b1);

    // Three valid samples in flight, then reset (with in_valid high) drops them.
    apply(8'hFF, 3'd0, 1'b1, 1'b0, 1'b1);
    apply(8'hFF, 3'd1, 1'b1, 1'b0, 1'b1);
    apply(8'hFF, 3'd2, 1'b1, 1'b0, 1'b1);
    apply(8'hFF, 3'd3, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < LATENCY + 1; i++) apply(8'h00, 3'd0, 1'b0, 1'b0, 1'b0);

    // Reset and in_valid together from an idle pipe.
    apply(8'hFF, 3'd7, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < LATENCY; i++) apply(8'h00, 3'd7, 1'b0, 1'b0, 1'b0);

`ifdef MUX8_1BIT_COMB_OUT_EN
    // out_comb follows in_7 before the edge while out still shows the old value.
    ins = 8'h80; sel = 3'd7; in_valid = 1'b1; rst = 1'b0;
    #1;
    chk_cnt++;
    if (out_comb === 1'b1 && out === 1'b0) pass_cnt++;
    else $display("FAIL comb_vs_reg: got out_comb=%b out=%b expected out_comb=1 out=0",
                  out_comb, out);
    apply(8'h80, 3'd7, 1'b1, 1'b0, 1'b1);
`endif

    for (int i = 0; i < LATENCY; i++) apply(8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire
